// File: rtl/riscv_id_pipe_pkg.sv
// riscv_id_pipe_pkg: shared RV32I decode definitions for the ID/issue stage.
// EX/memory function encodings, RV32I opcodes, decode record and immediate
// extraction helpers.
package riscv_id_pipe_pkg;

   // EX function encoding
   localparam int EX_FUNCT_W = 4;
   localparam logic [EX_FUNCT_W-1:0] EX_ADD  = 4'd0;
   localparam logic [EX_FUNCT_W-1:0] EX_SUB  = 4'd1;
   localparam logic [EX_FUNCT_W-1:0] EX_SLL  = 4'd2;
   localparam logic [EX_FUNCT_W-1:0] EX_STL  = 4'd3;
   localparam logic [EX_FUNCT_W-1:0] EX_STLU = 4'd4;
   localparam logic [EX_FUNCT_W-1:0] EX_XOR  = 4'd5;
   localparam logic [EX_FUNCT_W-1:0] EX_SRL  = 4'd6;
   localparam logic [EX_FUNCT_W-1:0] EX_SRA  = 4'd7;
   localparam logic [EX_FUNCT_W-1:0] EX_OR   = 4'd8;
   localparam logic [EX_FUNCT_W-1:0] EX_AND  = 4'd9;

   // Memory function encoding
   localparam int MEM_FUNCT_W = 4;
   localparam logic [MEM_FUNCT_W-1:0] MEM_NOP = 4'd0;
   localparam logic [MEM_FUNCT_W-1:0] MEM_LB  = 4'd1;
   localparam logic [MEM_FUNCT_W-1:0] MEM_LH  = 4'd2;
   localparam logic [MEM_FUNCT_W-1:0] MEM_LW  = 4'd3;
   localparam logic [MEM_FUNCT_W-1:0] MEM_LBU = 4'd4;
   localparam logic [MEM_FUNCT_W-1:0] MEM_LHU = 4'd5;
   localparam logic [MEM_FUNCT_W-1:0] MEM_SB  = 4'd6;
   localparam logic [MEM_FUNCT_W-1:0] MEM_SH  = 4'd7;
   localparam logic [MEM_FUNCT_W-1:0] MEM_SW  = 4'd8;

   // RV32I major opcodes handled (or recognised) by this stage
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      OP1_ZERO = 2'd0,
      OP1_RS1  = 2'd1,
      OP1_PC   = 2'd2
   } op1_sel_e;

   typedef enum logic [2:0] {
      OP2_ZERO  = 3'd0,
      OP2_RS2   = 3'd1,
      OP2_IMM_I = 3'd2,
      OP2_SHAMT = 3'd3,
      OP2_IMM_S = 3'd4,
      OP2_IMM_U = 3'd5
   } op2_sel_e;

   typedef struct packed {
      logic                   legal;
      logic                   use_rs1;
      logic                   use_rs2;
      logic                   wr_rd;
      logic                   is_store;
      logic [EX_FUNCT_W-1:0]  funct;
      logic [MEM_FUNCT_W-1:0] mem_funct;
      op1_sel_e               op1_sel;
      op2_sel_e               op2_sel;
   } decode_t;

   function automatic logic [31:0] imm_i(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:25], instr[11:7]};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] instr);
      return {instr[31:12], 12'd0};
   endfunction

endpackage

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32 x 32-bit register file, two combinational reads and one
// synchronous write. x0 always reads zero and ignores writes.
// REGFILE_RESET_ZERO=1 clears all registers on reset; 0 leaves them unreset.
module riscv_regfile #(
   parameter int REGFILE_RESET_ZERO = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);

   logic [31:0] regs_r [32];
   logic        wr_ok_s;

   assign wr_ok_s = wr_en & (wr_addr != 5'd0);

   generate
      if (REGFILE_RESET_ZERO != 0) begin : g_rst
         // register write with asynchronous clear of the whole file
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int i = 0; i < 32; i++) begin
                  regs_r[i] <= 32'd0;
               end
            end else if (wr_ok_s) begin
               regs_r[wr_addr] <= wr_data;
            end
         end
      end else begin : g_nrst
         logic rstn_unused_s;
         assign rstn_unused_s = rstn;
         // register write, contents not reset
         always_ff @(posedge clk) begin
            if (wr_ok_s) begin
               regs_r[wr_addr] <= wr_data;
            end
         end
      end
   endgenerate

   // combinational reads with x0 forced to zero
   always_comb begin
      rs1_data = 32'd0;
      rs2_data = 32'd0;
      if (rs1_addr != 5'd0) begin
         rs1_data = regs_r[rs1_addr];
      end else begin
         rs1_data = 32'd0;
      end
      if (rs2_addr != 5'd0) begin
         rs2_data = regs_r[rs2_addr];
      end else begin
         rs2_data = 32'd0;
      end
   end

endmodule

// File: rtl/riscv_id_pipe.sv
// riscv_id_pipe: RV32I decode/issue stage in front of the EX pipe.
// Decodes ALU, LUI/AUIPC, load and store, reads the register file, stalls
// RAW/WAW hazards through a pending-write scoreboard and issues one
// registered operation per transfer. Unsupported instructions are consumed
// and flagged on id_illegal.
// Optional macro RISCV_ID_WB_BYPASS_EN: forward wb_rf_data to a source that
// is being written back in the same cycle instead of stalling.
module riscv_id_pipe
   import riscv_id_pipe_pkg::*;
#(
   parameter int REGFILE_RESET_ZERO = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   if_id_rdy,
   input  logic [31:0]            if_id_instr,
   input  logic [31:0]            if_id_pc,
   output logic                   if_id_ack,
   output logic                   id_ex_rdy,
   input  logic                   id_ex_ack,
   output logic [EX_FUNCT_W-1:0]  id_ex_funct,
   output logic [31:0]            id_ex_op1,
   output logic [31:0]            id_ex_op2,
   output logic [MEM_FUNCT_W-1:0] id_ex_mem_funct,
   output logic [31:0]            id_ex_mem_data,
   output logic [4:0]             id_ex_wb_rsd,
   input  logic [31:0]            wb_rf_data,
   input  logic [4:0]             wb_rf_rsd,
   input  logic                   wb_rf_write,
   output logic                   id_illegal
);

   logic [6:0]  opcode_s;
   logic [4:0]  rd_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;
   logic        f7_zero_s;
   logic        f7_alt_s;
   decode_t     dec_s;

   logic [31:0] rf_rd1_s;
   logic [31:0] rf_rd2_s;
   logic        fwd1_s;
   logic        fwd2_s;
   logic [31:0] rs1v_s;
   logic [31:0] rs2v_s;
   logic [31:0] op1_s;
   logic [31:0] op2_s;
   logic [31:0] mem_data_s;
   logic [4:0]  wb_rsd_s;

   logic        hazard_s;
   logic        free_s;
   logic        accept_s;

   logic [31:0] busy_r;
   logic [31:0] set_mask_s;
   logic [31:0] clr_mask_s;
   logic [31:0] busy_nxt_s;

   assign opcode_s  = if_id_instr[6:0];
   assign rd_s      = if_id_instr[11:7];
   assign funct3_s  = if_id_instr[14:12];
   assign rs1_s     = if_id_instr[19:15];
   assign rs2_s     = if_id_instr[24:20];
   assign funct7_s  = if_id_instr[31:25];
   assign f7_zero_s = (funct7_s == F7_ZERO);
   assign f7_alt_s  = (funct7_s == F7_ALT);

   riscv_regfile #(
      .REGFILE_RESET_ZERO (REGFILE_RESET_ZERO)
   ) u_regfile (
      .clk      (clk),
      .rstn     (rstn),
      .rs1_addr (rs1_s),
      .rs2_addr (rs2_s),
      .rs1_data (rf_rd1_s),
      .rs2_data (rf_rd2_s),
      .wr_en    (wb_rf_write),
      .wr_addr  (wb_rf_rsd),
      .wr_data  (wb_rf_data)
   );

   // instruction decode into a control record; anything unmatched stays illegal
   always_comb begin
      dec_s.legal     = 1'b0;
      dec_s.use_rs1   = 1'b0;
      dec_s.use_rs2   = 1'b0;
      dec_s.wr_rd     = 1'b0;
      dec_s.is_store  = 1'b0;
      dec_s.funct     = EX_ADD;
      dec_s.mem_funct = MEM_NOP;
      dec_s.op1_sel   = OP1_ZERO;
      dec_s.op2_sel   = OP2_ZERO;
      case (opcode_s)
         OPC_OP: begin
            dec_s.use_rs1 = 1'b1;
            dec_s.use_rs2 = 1'b1;
            dec_s.wr_rd   = 1'b1;
            dec_s.op1_sel = OP1_RS1;
            dec_s.op2_sel = OP2_RS2;
            case (funct3_s)
               3'b000: begin
                  dec_s.legal = f7_zero_s | f7_alt_s;
                  dec_s.funct = f7_alt_s ? EX_SUB : EX_ADD;
               end
               3'b001: begin dec_s.legal = f7_zero_s; dec_s.funct = EX_SLL;  end
               3'b010: begin dec_s.legal = f7_zero_s; dec_s.funct = EX_STL;  end
               3'b011: begin dec_s.legal = f7_zero_s; dec_s.funct = EX_STLU; end
               3'b100: begin dec_s.legal = f7_zero_s; dec_s.funct = EX_XOR;  end
               3'b101: begin
                  dec_s.legal = f7_zero_s | f7_alt_s;
                  dec_s.funct = f7_alt_s ? EX_SRA : EX_SRL;
               end
               3'b110: begin dec_s.legal = f7_zero_s; dec_s.funct = EX_OR;   end
               3'b111: begin dec_s.legal = f7_zero_s; dec_s.funct = EX_AND;  end
               default: dec_s.legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            dec_s.use_rs1 = 1'b1;
            dec_s.wr_rd   = 1'b1;
            dec_s.legal   = 1'b1;
            dec_s.op1_sel = OP1_RS1;
            dec_s.op2_sel = OP2_IMM_I;
            case (funct3_s)
               3'b000: dec_s.funct = EX_ADD;
               3'b010: dec_s.funct = EX_STL;
               3'b011: dec_s.funct = EX_STLU;
               3'b100: dec_s.funct = EX_XOR;
               3'b110: dec_s.funct = EX_OR;
               3'b111: dec_s.funct = EX_AND;
               3'b001: begin
                  dec_s.legal   = f7_zero_s;
                  dec_s.funct   = EX_SLL;
                  dec_s.op2_sel = OP2_SHAMT;
               end
               3'b101: begin
                  dec_s.legal   = f7_zero_s | f7_alt_s;
                  dec_s.funct   = f7_alt_s ? EX_SRA : EX_SRL;
                  dec_s.op2_sel = OP2_SHAMT;
               end
               default: dec_s.legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            dec_s.legal   = 1'b1;
            dec_s.wr_rd   = 1'b1;
            dec_s.op1_sel = OP1_ZERO;
            dec_s.op2_sel = OP2_IMM_U;
         end
         OPC_AUIPC: begin
            dec_s.legal   = 1'b1;
            dec_s.wr_rd   = 1'b1;
            dec_s.op1_sel = OP1_PC;
            dec_s.op2_sel = OP2_IMM_U;
         end
         OPC_LOAD: begin
            dec_s.use_rs1 = 1'b1;
            dec_s.wr_rd   = 1'b1;
            dec_s.legal   = 1'b1;
            dec_s.op1_sel = OP1_RS1;
            dec_s.op2_sel = OP2_IMM_I;
            case (funct3_s)
               3'b000:  dec_s.mem_funct = MEM_LB;
               3'b001:  dec_s.mem_funct = MEM_LH;
               3'b010:  dec_s.mem_funct = MEM_LW;
               3'b100:  dec_s.mem_funct = MEM_LBU;
               3'b101:  dec_s.mem_funct = MEM_LHU;
               default: dec_s.legal     = 1'b0;
            endcase
         end
         OPC_STORE: begin
            dec_s.use_rs1  = 1'b1;
            dec_s.use_rs2  = 1'b1;
            dec_s.is_store = 1'b1;
            dec_s.legal    = 1'b1;
            dec_s.op1_sel  = OP1_RS1;
            dec_s.op2_sel  = OP2_IMM_S;
            case (funct3_s)
               3'b000:  dec_s.mem_funct = MEM_SB;
               3'b001:  dec_s.mem_funct = MEM_SH;
               3'b010:  dec_s.mem_funct = MEM_SW;
               default: dec_s.legal     = 1'b0;
            endcase
         end
         default: dec_s.legal = 1'b0;
      endcase
   end

`ifdef RISCV_ID_WB_BYPASS_EN
   assign fwd1_s = wb_rf_write & (wb_rf_rsd == rs1_s) & (rs1_s != 5'd0);
   assign fwd2_s = wb_rf_write & (wb_rf_rsd == rs2_s) & (rs2_s != 5'd0);
`else
   assign fwd1_s = 1'b0;
   assign fwd2_s = 1'b0;
`endif

   // operand selection; a forwarded source takes the write-back value
   always_comb begin
      rs1v_s = fwd1_s ? wb_rf_data : rf_rd1_s;
      rs2v_s = fwd2_s ? wb_rf_data : rf_rd2_s;
      op1_s  = 32'd0;
      op2_s  = 32'd0;
      case (dec_s.op1_sel)
         OP1_RS1: op1_s = rs1v_s;
         OP1_PC:  op1_s = if_id_pc;
         default: op1_s = 32'd0;
      endcase
      case (dec_s.op2_sel)
         OP2_RS2:   op2_s = rs2v_s;
         OP2_IMM_I: op2_s = imm_i(if_id_instr);
         OP2_SHAMT: op2_s = {27'd0, if_id_instr[24:20]};
         OP2_IMM_S: op2_s = imm_s(if_id_instr);
         OP2_IMM_U: op2_s = imm_u(if_id_instr);
         default:   op2_s = 32'd0;
      endcase
      mem_data_s = dec_s.is_store ? rs2v_s : 32'd0;
      wb_rsd_s   = (dec_s.legal && dec_s.wr_rd) ? rd_s : 5'd0;
   end

   // hazard detection against the scoreboard and the issue handshake
   always_comb begin
      hazard_s = 1'b0;
      if (dec_s.legal) begin
         hazard_s = (dec_s.use_rs1 & (rs1_s != 5'd0) & busy_r[rs1_s] & ~fwd1_s) |
                    (dec_s.use_rs2 & (rs2_s != 5'd0) & busy_r[rs2_s] & ~fwd2_s) |
                    ((wb_rsd_s != 5'd0) & busy_r[wb_rsd_s]);
      end else begin
         hazard_s = 1'b0;
      end
      free_s    = ~id_ex_rdy | id_ex_ack;
      accept_s  = if_id_rdy & free_s & ~hazard_s;
      if_id_ack = accept_s;
   end

   // scoreboard next state: write-back clears, accept sets, set wins
   always_comb begin
      set_mask_s = 32'd0;
      clr_mask_s = 32'd0;
      if (accept_s && (wb_rsd_s != 5'd0)) begin
         set_mask_s = 32'd1 << wb_rsd_s;
      end else begin
         set_mask_s = 32'd0;
      end
      if (wb_rf_write) begin
         clr_mask_s = 32'd1 << wb_rf_rsd;
      end else begin
         clr_mask_s = 32'd0;
      end
      busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
   end

   // scoreboard register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_r <= 32'd0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   // output stage: load on legal accept, hold while EX stalls
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         id_ex_rdy       <= 1'b0;
         id_ex_funct     <= '0;
         id_ex_op1       <= 32'd0;
         id_ex_op2       <= 32'd0;
         id_ex_mem_funct <= '0;
         id_ex_mem_data  <= 32'd0;
         id_ex_wb_rsd    <= 5'd0;
         id_illegal      <= 1'b0;
      end else begin
         id_illegal <= accept_s & ~dec_s.legal;
         if (free_s) begin
            id_ex_rdy <= accept_s & dec_s.legal;
         end
         if (accept_s && dec_s.legal) begin
            id_ex_funct     <= dec_s.funct;
            id_ex_op1       <= op1_s;
            id_ex_op2       <= op2_s;
            id_ex_mem_funct <= dec_s.mem_funct;
            id_ex_mem_data  <= mem_data_s;
            id_ex_wb_rsd    <= wb_rsd_s;
         end
      end
   end

endmodule

// File: tb/tb_riscv_id_pipe.sv
// tb_riscv_id_pipe: directed self-checking bench for riscv_id_pipe.
// Honours RISCV_ID_WB_BYPASS_EN for the write-back timing step.
module tb_riscv_id_pipe;

   // expected encodings, written out by hand
   localparam logic [3:0] X_EX_ADD  = 4'd0;
   localparam logic [3:0] X_EX_SRA  = 4'd7;
   localparam logic [3:0] X_MEM_NOP = 4'd0;
   localparam logic [3:0] X_MEM_LW  = 4'd3;
   localparam logic [3:0] X_MEM_SW  = 4'd8;

   logic        clk;
   logic        rstn;
   logic        if_id_rdy;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        if_id_ack;
   logic        id_ex_rdy;
   logic        id_ex_ack;
   logic [3:0]  id_ex_funct;
   logic [31:0] id_ex_op1;
   logic [31:0] id_ex_op2;
   logic [3:0]  id_ex_mem_funct;
   logic [31:0] id_ex_mem_data;
   logic [4:0]  id_ex_wb_rsd;
   logic [31:0] wb_rf_data;
   logic [4:0]  wb_rf_rsd;
   logic        wb_rf_write;
   logic        id_illegal;

   int passed;
   int total;

   riscv_id_pipe #(.REGFILE_RESET_ZERO(1)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .if_id_rdy       (if_id_rdy),
      .if_id_instr     (if_id_instr),
      .if_id_pc        (if_id_pc),
      .if_id_ack       (if_id_ack),
      .id_ex_rdy       (id_ex_rdy),
      .id_ex_ack       (id_ex_ack),
      .id_ex_funct     (id_ex_funct),
      .id_ex_op1       (id_ex_op1),
      .id_ex_op2       (id_ex_op2),
      .id_ex_mem_funct (id_ex_mem_funct),
      .id_ex_mem_data  (id_ex_mem_data),
      .id_ex_wb_rsd    (id_ex_wb_rsd),
      .wb_rf_data      (wb_rf_data),
      .wb_rf_rsd       (wb_rf_rsd),
      .wb_rf_write     (wb_rf_write),
      .id_illegal      (id_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      passed      = 0;
      total       = 0;
      rstn        = 1'b0;
      if_id_rdy   = 1'b0;
      if_id_instr = 32'd0;
      if_id_pc    = 32'd0;
      id_ex_ack   = 1'b1;
      wb_rf_data  = 32'd0;
      wb_rf_rsd   = 5'd0;
      wb_rf_write = 1'b0;
      step();
      step();
      chk("rst_rdy",     id_ex_rdy,    32'd0);
      chk("rst_op1",     id_ex_op1,    32'd0);
      chk("rst_op2",     id_ex_op2,    32'd0);
      chk("rst_wb_rsd",  id_ex_wb_rsd, 32'd0);
      chk("rst_illegal", id_illegal,   32'd0);
      chk("rst_if_ack",  if_id_ack,    32'd0);
      rstn = 1'b1;
      step();

      // addi x1,x0,5
      if_id_rdy = 1'b1; if_id_instr = 32'h0050_0093; if_id_pc = 32'h0000_0000;
      #1 chk("addi_if_ack", if_id_ack, 32'd1);
      step();
      chk("addi_rdy",   id_ex_rdy,       32'd1);
      chk("addi_funct", id_ex_funct,     X_EX_ADD);
      chk("addi_op1",   id_ex_op1,       32'd0);
      chk("addi_op2",   id_ex_op2,       32'd5);
      chk("addi_rsd",   id_ex_wb_rsd,    32'd1);
      chk("addi_mem",   id_ex_mem_funct, X_MEM_NOP);

      // add x2,x1,x1 stalls on busy x1
      if_id_instr = 32'h0010_8133; if_id_pc = 32'h0000_0004;
      #1 chk("raw_stall_ack", if_id_ack, 32'd0);
      step();
      chk("raw_stall_rdy", id_ex_rdy, 32'd0);
      chk("raw_stall_ack2", if_id_ack, 32'd0);
      wb_rf_write = 1'b1; wb_rf_rsd = 5'd1; wb_rf_data = 32'd5;
`ifdef RISCV_ID_WB_BYPASS_EN
      #1 chk("bypass_ack", if_id_ack, 32'd1);
      step();
      wb_rf_write = 1'b0;
`else
      #1 chk("wb_cycle_ack", if_id_ack, 32'd0);
      step();
      wb_rf_write = 1'b0;
      chk("wb_cycle_rdy", id_ex_rdy, 32'd0);
      #1 chk("after_wb_ack", if_id_ack, 32'd1);
      step();
`endif
      if_id_rdy = 1'b0;
      chk("add_rdy", id_ex_rdy,    32'd1);
      chk("add_op1", id_ex_op1,    32'd5);
      chk("add_op2", id_ex_op2,    32'd5);
      chk("add_rsd", id_ex_wb_rsd, 32'd2);

      // write-back x2=0x100, x3=0xDEADBEEF
      wb_rf_write = 1'b1; wb_rf_rsd = 5'd2; wb_rf_data = 32'h0000_0100;
      step();
      wb_rf_rsd = 5'd3; wb_rf_data = 32'hDEAD_BEEF;
      step();
      wb_rf_write = 1'b0;

      // sw x3,8(x2)
      if_id_rdy = 1'b1; if_id_instr = 32'h0031_2423; if_id_pc = 32'h0000_0008;
      #1 chk("sw_if_ack", if_id_ack, 32'd1);
      step();
      chk("sw_op1",  id_ex_op1,       32'h0000_0100);
      chk("sw_op2",  id_ex_op2,       32'd8);
      chk("sw_mem",  id_ex_mem_funct, X_MEM_SW);
      chk("sw_data", id_ex_mem_data,  32'hDEAD_BEEF);
      chk("sw_rsd",  id_ex_wb_rsd,    32'd0);

      // lui x5,0x12345 back to back
      if_id_instr = 32'h1234_52B7; if_id_pc = 32'h0000_0040;
      #1 chk("lui_if_ack", if_id_ack, 32'd1);
      step();
      chk("lui_rdy", id_ex_rdy,    32'd1);
      chk("lui_op1", id_ex_op1,    32'd0);
      chk("lui_op2", id_ex_op2,    32'h1234_5000);
      chk("lui_rsd", id_ex_wb_rsd, 32'd5);
      chk("lui_data", id_ex_mem_data, 32'd0);

      // auipc x6,1 at pc 0x40
      if_id_instr = 32'h0000_1317; if_id_pc = 32'h0000_0040;
      step();
      chk("auipc_op1", id_ex_op1,    32'h0000_0040);
      chk("auipc_op2", id_ex_op2,    32'h0000_1000);
      chk("auipc_rsd", id_ex_wb_rsd, 32'd6);

      // EX stalls 3 cycles with addi x7,x0,-1 waiting
      id_ex_ack = 1'b0; if_id_instr = 32'hFFF0_0393; if_id_pc = 32'h0000_0044;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_if_ack", if_id_ack, 32'd0);
         step();
         chk("stall_rdy", id_ex_rdy,    32'd1);
         chk("stall_op1", id_ex_op1,    32'h0000_0040);
         chk("stall_rsd", id_ex_wb_rsd, 32'd6);
      end
      id_ex_ack = 1'b1;
      #1 chk("unstall_if_ack", if_id_ack, 32'd1);
      step();
      chk("addim1_op1", id_ex_op1,    32'd0);
      chk("addim1_op2", id_ex_op2,    32'hFFFF_FFFF);
      chk("addim1_rsd", id_ex_wb_rsd, 32'd7);

      // srai x8,x0,3
      if_id_instr = 32'h4030_5413; if_id_pc = 32'h0000_0048;
      step();
      chk("srai_funct", id_ex_funct,  X_EX_SRA);
      chk("srai_op2",   id_ex_op2,    32'd3);
      chk("srai_rsd",   id_ex_wb_rsd, 32'd8);

      // beq is consumed as illegal
      if_id_instr = 32'h0000_0063; if_id_pc = 32'h0000_004C;
      #1 chk("beq_if_ack", if_id_ack, 32'd1);
      step();
      chk("beq_illegal", id_illegal, 32'd1);
      chk("beq_rdy",     id_ex_rdy,  32'd0);
      // load with funct3=3 is illegal too
      if_id_instr = 32'h0000_3003; if_id_pc = 32'h0000_0050;
      #1 chk("ld3_if_ack", if_id_ack, 32'd1);
      step();
      if_id_rdy = 1'b0;
      chk("ld3_illegal", id_illegal, 32'd1);
      chk("ld3_rdy",     id_ex_rdy,  32'd0);
      step();
      chk("illegal_pulse_end", id_illegal, 32'd0);

      // lw x10,4(x0), then EX stalls and reset hits
      if_id_rdy = 1'b1; if_id_instr = 32'h0040_2503; if_id_pc = 32'h0000_0054;
      step();
      if_id_rdy = 1'b0; id_ex_ack = 1'b0;
      chk("lw_mem", id_ex_mem_funct, X_MEM_LW);
      chk("lw_op2", id_ex_op2,       32'd4);
      chk("lw_rsd", id_ex_wb_rsd,    32'd10);
      step();
      chk("lw_hold_rdy", id_ex_rdy, 32'd1);
      rstn = 1'b0;
      #1;
      chk("midrst_rdy", id_ex_rdy,    32'd0);
      chk("midrst_op2", id_ex_op2,    32'd0);
      chk("midrst_rsd", id_ex_wb_rsd, 32'd0);
      step();
      rstn = 1'b1; id_ex_ack = 1'b1;
      step();

      // addi x12,x10,1: x10 no longer busy after reset
      if_id_rdy = 1'b1; if_id_instr = 32'h0015_0613; if_id_pc = 32'h0000_0058;
      #1 chk("postrst_if_ack", if_id_ack, 32'd1);
      step();
      if_id_rdy = 1'b0;
      chk("postrst_rdy", id_ex_rdy,    32'd1);
      chk("postrst_op1", id_ex_op1,    32'd0);
      chk("postrst_op2", id_ex_op2,    32'd1);
      chk("postrst_rsd", id_ex_wb_rsd, 32'd12);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
